data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
Shares one data-memory slave port between two requesters. M0 is the core's load/store port; the core holds its PC until m0_ready. M1 is the loader/DMA/debug port. Each request is latched and forwarded as a single registered slave transaction. Arbitration is round-robin between the two masters. A per-transaction timeout completes hung accesses with an error.

Parameters:
ADDR_WIDTH, 32, address width of masters and slave
DATA_WIDTH, 32, data width; must be a multiple of 8
TIMEOUT, 16, max cycles to wait for s_ready in BUSY; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
m0_valid  in  1  M0 request
m0_addr  in  ADDR_WIDTH  M0 byte address
m0_wdata  in  DATA_WIDTH  M0 write data
m0_we  in  DATA_WIDTH/8  M0 byte write enables; all zero means read
m0_ready  out  1  one-cycle completion pulse to M0
m0_rdata  out  DATA_WIDTH  read data; valid with m0_ready
m0_err  out  1  timeout flag; valid with m0_ready
m1_valid, m1_addr, m1_wdata, m1_we, m1_ready, m1_rdata, m1_err  same as M0, for M1
s_valid  out  1  slave request
s_addr  out  ADDR_WIDTH  latched address
s_wdata  out  DATA_WIDTH  latched write data
s_we  out  DATA_WIDTH/8  latched byte enables
s_ready  in  1  slave completion; s_rdata valid in the same cycle
s_rdata  in  DATA_WIDTH  slave read data

Behaviour:
- Reset (asynchronous, any state): state=IDLE; every output 0; last_grant=M1, so M0 wins the first tie; timeout counter=0.
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - If only one valid is high, grant it. If both are high, grant the master that is not last_grant.
  - On grant: latch addr/wdata/we and the grant id; next state BUSY; s_valid=1 from the next cycle.
  - If no valid is high, stay in IDLE.
- BUSY:
  - s_valid stays 1; s_addr/s_wdata/s_we are held stable from the latch.
  - On s_ready=1: register s_rdata (reads only; writes return 0); s_valid<=0; err<=0; next state RESP.
  - If TIMEOUT>0, the counter is cleared on BUSY entry and increments each BUSY cycle without s_ready.
  - If counter==TIMEOUT-1 and s_ready=0: s_valid<=0, rdata<=0, err<=1, next state RESP.
  - If s_ready arrives in that same cycle, it wins: normal completion, no error.
- RESP:
  - Exactly one cycle. mX_ready=1 for the granted master only, with mX_rdata and mX_err.
  - last_grant<=granted id; next state IDLE.
  - The other master's ready, rdata and err stay 0.
- Latency: valid sampled in IDLE at cycle T → s_valid at T+1. If s_ready at T+k (k≥1) → mX_ready at T+k+1.
- Masters hold valid and payload stable until ready. Valid is not sampled during BUSY or RESP.
- A master that keeps valid high after its ready pulse is seen in IDLE as a new request. With both masters continuously requesting, grants strictly alternate.
- s_ready outside BUSY is ignored.
- mX_rdata and mX_err are zero whenever mX_ready=0.
- Counter width is $clog2(TIMEOUT+1). With TIMEOUT=0 the counter logic is absent and BUSY waits forever.

Decomposition:
- Shared package: FSM state encoding (IDLE, BUSY, RESP), master id constants (MID_M0=0, MID_M1=1), ERR_NONE/ERR_TIMEOUT.
- One natural sub-module: bus_rr_pick. It is combinational: inputs valid[1:0] and last_grant; outputs grant_valid and grant_id. The FSM and latches stay in the top module.

Test Plan:
1. After reset, M0 reads 0x0000_0100; slave gives s_ready at T+1 with 0xDEADBEEF → s_addr=0x100 and s_we=0 at T+1; m0_ready=1 with m0_rdata=0xDEADBEEF at T+2; m1_ready stays 0.
2. Both masters valid from reset, slave always ready → grant order M0, M1, M0, M1. Each transaction completes 3 cycles after the previous one; m0_ready and m1_ready pulses alternate.
3. M1 writes addr 0x204, wdata 0xA5A5_1234, we=4'b0011; slave delays s_ready to T+4 → s_valid, s_we=0011 and s_wdata stable over T+1..T+4; m1_ready at T+5 with m1_rdata=0, m1_err=0.
4. TIMEOUT=8, M0 read, s_ready never asserted → s_valid high T+1..T+8; m0_ready=1, m0_err=1, m0_rdata=0 at T+9; next M0 request is served normally.
5. rst pulsed while in BUSY → s_valid and all outputs 0 immediately, without waiting for clk. After release, simultaneous requests grant M0 first.
6. s_ready asserted while in IDLE with no request → no ready pulses, state stays IDLE. s_ready at the exact timeout cycle → normal completion with err=0.

Source files
------------

// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and constants for the two-master data bus arbiter.
// Imported by the arbiter top and its round-robin picker.
package data_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic MID_M0 = 1'b0;
   localparam logic MID_M1 = 1'b1;

   localparam logic ERR_NONE    = 1'b0;
   localparam logic ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/data_bus_arbiter_rr_pick.sv
// Combinational round-robin choice between the two bus masters.
// A tie goes to the master that did not win the previous grant.
module bus_rr_pick
   import data_bus_arbiter_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_id
);

   // pick the sole requester, or alternate away from last_grant on a tie
   always_comb begin
      grant_valid = |valid;
      grant_id    = MID_M0;
      unique case (valid)
         2'b01:   grant_id = MID_M0;
         2'b10:   grant_id = MID_M1;
         2'b11:   grant_id = ~last_grant;
         default: grant_id = MID_M0;
      endcase
   end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter: latches one request, forwards it as a
// registered slave transaction and returns a one-cycle response.
module data_bus_arbiter
   import data_bus_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    m0_valid,
   input  logic [ADDR_WIDTH-1:0]   m0_addr,
   input  logic [DATA_WIDTH-1:0]   m0_wdata,
   input  logic [DATA_WIDTH/8-1:0] m0_we,
   output logic                    m0_ready,
   output logic [DATA_WIDTH-1:0]   m0_rdata,
   output logic                    m0_err,

   input  logic                    m1_valid,
   input  logic [ADDR_WIDTH-1:0]   m1_addr,
   input  logic [DATA_WIDTH-1:0]   m1_wdata,
   input  logic [DATA_WIDTH/8-1:0] m1_we,
   output logic                    m1_ready,
   output logic [DATA_WIDTH-1:0]   m1_rdata,
   output logic                    m1_err,

   output logic                    s_valid,
   output logic [ADDR_WIDTH-1:0]   s_addr,
   output logic [DATA_WIDTH-1:0]   s_wdata,
   output logic [DATA_WIDTH/8-1:0] s_we,
   input  logic                    s_ready,
   input  logic [DATA_WIDTH-1:0]   s_rdata
);

   localparam int BW = DATA_WIDTH / 8;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t                state;
   logic                  gnt_id;
   logic                  last_grant;
   logic                  grant_valid;
   logic                  grant_id;
   logic                  tmo_hit;
   logic                  is_read;
   logic                  done;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_err;
   logic [ADDR_WIDTH-1:0] pick_addr;
   logic [DATA_WIDTH-1:0] pick_wdata;
   logic [BW-1:0]         pick_we;

   bus_rr_pick u_pick (
      .valid       ({m1_valid, m0_valid}),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign is_read = (s_we == '0);
   assign done    = s_ready | tmo_hit;

   // payload of whichever master the picker chose
   always_comb begin
      pick_addr  = m0_addr;
      pick_wdata = m0_wdata;
      pick_we    = m0_we;
      if (grant_id == MID_M1) begin
         pick_addr  = m1_addr;
         pick_wdata = m1_wdata;
         pick_we    = m1_we;
      end
   end

   // slave completion beats timeout; writes return zero data
   always_comb begin
      rsp_data = '0;
      rsp_err  = ERR_TIMEOUT;
      if (s_ready) begin
         rsp_err = ERR_NONE;
         if (is_read) begin
            rsp_data = s_rdata;
         end
      end
   end

   generate
      if (TIMEOUT > 0) begin : g_tmo
         logic [CW-1:0] cnt;

         // count BUSY cycles spent waiting on the slave
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt <= '0;
            end else if (state != BUSY) begin
               cnt <= '0;
            end else if (!s_ready) begin
               cnt <= cnt + 1'b1;
            end
         end

         assign tmo_hit = (state == BUSY) &&
                          (cnt == CW'(TIMEOUT - 1));
      end else begin : g_no_tmo
         assign tmo_hit = 1'b0;
      end
   endgenerate

   // arbitration FSM with registered slave and master outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         gnt_id     <= MID_M0;
         last_grant <= MID_M1;
         s_valid    <= 1'b0;
         s_addr     <= '0;
         s_wdata    <= '0;
         s_we       <= '0;
         m0_ready   <= 1'b0;
         m0_rdata   <= '0;
         m0_err     <= ERR_NONE;
         m1_ready   <= 1'b0;
         m1_rdata   <= '0;
         m1_err     <= ERR_NONE;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_valid) begin
                  gnt_id  <= grant_id;
                  s_addr  <= pick_addr;
                  s_wdata <= pick_wdata;
                  s_we    <= pick_we;
                  s_valid <= 1'b1;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (done) begin
                  s_valid <= 1'b0;
                  state   <= RESP;
                  if (gnt_id == MID_M0) begin
                     m0_ready <= 1'b1;
                     m0_rdata <= rsp_data;
                     m0_err   <= rsp_err;
                  end else begin
                     m1_ready <= 1'b1;
                     m1_rdata <= rsp_data;
                     m1_err   <= rsp_err;
                  end
               end
            end
            RESP: begin
               m0_ready   <= 1'b0;
               m0_rdata   <= '0;
               m0_err     <= ERR_NONE;
               m1_ready   <= 1'b0;
               m1_rdata   <= '0;
               m1_err     <= ERR_NONE;
               last_grant <= gnt_id;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: directed scenarios plus
// random traffic compared every cycle against a transaction-level model.
module tb_data_bus_arbiter;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_valid, m1_valid;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_we, m1_we;
   logic        m0_ready, m1_ready, m0_err, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_valid, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_we;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   data_bus_arbiter #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .TIMEOUT    (TMO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .m0_valid (m0_valid),
      .m0_addr  (m0_addr),
      .m0_wdata (m0_wdata),
      .m0_we    (m0_we),
      .m0_ready (m0_ready),
      .m0_rdata (m0_rdata),
      .m0_err   (m0_err),
      .m1_valid (m1_valid),
      .m1_addr  (m1_addr),
      .m1_wdata (m1_wdata),
      .m1_we    (m1_we),
      .m1_ready (m1_ready),
      .m1_rdata (m1_rdata),
      .m1_err   (m1_err),
      .s_valid  (s_valid),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_we     (s_we),
      .s_ready  (s_ready),
      .s_rdata  (s_rdata)
   );

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // One outstanding transaction at most; a transaction lives as
   // "waiting on slave" for age cycles, then one response cycle.
   bit          t_open = 0;
   bit          t_resp = 0;
   int          t_owner = 0;
   int          t_age = 0;
   int          last_win = 1;
   logic [31:0] t_addr = 0, t_wdata = 0;
   logic [3:0]  t_we = 0;
   logic        e_svalid = 0;
   logic        e_ready [2] = '{0, 0};
   logic [31:0] e_rdata [2] = '{0, 0};
   logic        e_err   [2] = '{0, 0};

   task automatic m_close(logic [31:0] d, logic er);
      t_open = 0;
      t_resp = 1;
      e_svalid = 0;
      e_ready[t_owner] = 1;
      e_rdata[t_owner] = d;
      e_err[t_owner] = er;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         t_open = 0; t_resp = 0; t_age = 0; last_win = 1;
         t_addr = 0; t_wdata = 0; t_we = 0; e_svalid = 0;
         for (int i = 0; i < 2; i++) begin
            e_ready[i] = 0; e_rdata[i] = 0; e_err[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            e_ready[i] = 0; e_rdata[i] = 0; e_err[i] = 0;
         end
         if (t_resp) begin
            t_resp = 0;
            last_win = t_owner;
         end else if (t_open) begin
            t_age++;
            if (s_ready)
               m_close((t_we == 0) ? s_rdata : 32'h0, 1'b0);
            else if (TMO > 0 && t_age == TMO)
               m_close(32'h0, 1'b1);
         end else if (m0_valid || m1_valid) begin
            if (m0_valid && m1_valid) t_owner = 1 - last_win;
            else t_owner = m1_valid ? 1 : 0;
            t_addr  = t_owner ? m1_addr  : m0_addr;
            t_wdata = t_owner ? m1_wdata : m0_wdata;
            t_we    = t_owner ? m1_we    : m0_we;
            t_open = 1; t_age = 0; e_svalid = 1;
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      chk("s_valid", s_valid, e_svalid);
      if (e_svalid) begin
         chk("s_addr", s_addr, t_addr);
         chk("s_wdata", s_wdata, t_wdata);
         chk("s_we", s_we, t_we);
      end
      chk("m0_ready", m0_ready, e_ready[0]);
      chk("m0_rdata", m0_rdata, e_rdata[0]);
      chk("m0_err", m0_err, e_err[0]);
      chk("m1_ready", m1_ready, e_ready[1]);
      chk("m1_rdata", m1_rdata, e_rdata[1]);
      chk("m1_err", m1_err, e_err[1]);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_all();
      m0_valid = 0; m1_valid = 0; s_ready = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic new_req(int i);
      logic [31:0] a, d;
      logic [3:0]  w;
      a = $urandom & 32'hFFFF_FFFC;
      d = $urandom;
      w = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
      if (i == 0) begin
         m0_valid = 1; m0_addr = a; m0_wdata = d; m0_we = w;
      end else begin
         m1_valid = 1; m1_addr = a; m1_wdata = d; m1_we = w;
      end
   endtask

   int hang_left = 0;

   initial begin
      int n, hi, at;
      int ord [4];
      int cy [4];
      int exp_ord [4];
      rst = 1;
      idle_all();
      s_rdata = 0;
      m0_addr = 0; m0_wdata = 0; m0_we = 0;
      m1_addr = 0; m1_wdata = 0; m1_we = 0;
      repeat (2) tick();
      chk("reset_svalid", s_valid, 0);
      chk("reset_m0_ready", m0_ready, 0);
      chk("reset_m1_ready", m1_ready, 0);
      rst = 0;

      // 1: single M0 read, slave ready at once
      m0_valid = 1; m0_addr = 32'h100; m0_we = 0; m0_wdata = 0;
      tick();
      chk("t1_svalid", s_valid, 1);
      chk("t1_saddr", s_addr, 32'h100);
      chk("t1_swe", s_we, 0);
      s_ready = 1; s_rdata = 32'hDEADBEEF;
      tick();
      chk("t1_m0_ready", m0_ready, 1);
      chk("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
      chk("t1_m1_ready", m1_ready, 0);
      idle_all();
      tick();

      // 2: both requesting from reset, slave always ready
      do_reset();
      m0_valid = 1; m0_addr = 32'h10; m0_we = 0;
      m1_valid = 1; m1_addr = 32'h20; m1_we = 0;
      s_ready = 1; s_rdata = 32'h1111_2222;
      n = 0;
      for (int c = 0; c < 30 && n < 4; c++) begin
         tick();
         if (m0_ready || m1_ready) begin
            ord[n] = m1_ready ? 1 : 0;
            cy[n] = c;
            n++;
            if (n == 4) begin
               m0_valid = 0; m1_valid = 0;
            end
         end
      end
      chk("t2_pulses", n, 4);
      exp_ord = '{0, 1, 0, 1};
      for (int i = 0; i < n; i++) chk("t2_order", ord[i], exp_ord[i]);
      for (int i = 1; i < n; i++) chk("t2_gap", cy[i] - cy[i-1], 3);
      idle_all();
      tick();

      // 3: M1 byte write, slave delays completion
      m1_valid = 1; m1_addr = 32'h204;
      m1_wdata = 32'hA5A5_1234; m1_we = 4'b0011;
      s_rdata = 32'h5555_AAAA;
      tick();
      for (int i = 1; i <= 4; i++) begin
         chk("t3_svalid", s_valid, 1);
         chk("t3_swe", s_we, 4'b0011);
         chk("t3_swdata", s_wdata, 32'hA5A5_1234);
         if (i == 4) s_ready = 1;
         tick();
      end
      chk("t3_m1_ready", m1_ready, 1);
      chk("t3_m1_rdata", m1_rdata, 0);
      chk("t3_m1_err", m1_err, 0);
      idle_all();
      tick();

      // 4: hung slave times out
      m0_valid = 1; m0_addr = 32'h300; m0_we = 0;
      hi = 0; at = -1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (m0_ready) begin
            at = c;
            chk("t4_err", m0_err, 1);
            chk("t4_rdata", m0_rdata, 0);
            break;
         end
         if (s_valid) hi++;
      end
      chk("t4_ready_cycle", at, 9);
      chk("t4_svalid_cycles", hi, 8);
      m0_addr = 32'h304;
      s_ready = 1; s_rdata = 32'hCAFE_0001;
      at = -1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (m0_ready) begin
            at = c;
            chk("t4_next_err", m0_err, 0);
            chk("t4_next_rdata", m0_rdata, 32'hCAFE_0001);
            break;
         end
      end
      chk("t4_next_seen", at > 0, 1);
      idle_all();
      tick();

      // 5: asynchronous reset in BUSY
      m0_valid = 1; m0_addr = 32'h400; m0_we = 0;
      tick();
      tick();
      chk("t5_busy", s_valid, 1);
      #1 rst = 1;
      #1;
      chk("t5_async_svalid", s_valid, 0);
      chk("t5_async_saddr", s_addr, 0);
      chk("t5_async_m0_ready", m0_ready, 0);
      chk("t5_async_m1_ready", m1_ready, 0);
      m0_valid = 0;
      tick();
      m0_valid = 1; m0_addr = 32'h500;
      m1_valid = 1; m1_addr = 32'h600; m1_we = 0;
      rst = 0;
      tick();
      chk("t5_first_grant", s_addr, 32'h500);
      s_ready = 1;
      tick();
      chk("t5_m0_first", m0_ready, 1);
      m0_valid = 0;
      at = -1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (m1_ready) begin at = c; break; end
      end
      chk("t5_m1_served", at > 0, 1);
      idle_all();
      tick();

      // 6: stray s_ready in IDLE, then s_ready on the timeout cycle
      s_ready = 1;
      repeat (5) begin
         tick();
         chk("t6_idle_svalid", s_valid, 0);
         chk("t6_idle_ready", m0_ready | m1_ready, 0);
      end
      s_ready = 0; s_rdata = 32'h0000_0077;
      m0_valid = 1; m0_addr = 32'h700; m0_we = 0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         chk("t6_svalid", s_valid, 1);
         if (c == 8) s_ready = 1;
      end
      tick();
      chk("t6_ready", m0_ready, 1);
      chk("t6_err", m0_err, 0);
      chk("t6_rdata", m0_rdata, 32'h0000_0077);
      idle_all();
      tick();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         if (e_ready[0]) begin
            if ($urandom % 2 == 0) m0_valid = 0; else new_req(0);
         end else if (!m0_valid && $urandom % 3 == 0) begin
            new_req(0);
         end
         if (e_ready[1]) begin
            if ($urandom % 2 == 0) m1_valid = 0; else new_req(1);
         end else if (!m1_valid && $urandom % 3 == 0) begin
            new_req(1);
         end
         if (hang_left > 0) begin
            hang_left--;
            s_ready = 0;
         end else if ($urandom % 40 == 0) begin
            hang_left = $urandom_range(6, 12);
            s_ready = 0;
         end else begin
            s_ready = ($urandom % 3 == 0);
         end
         s_rdata = $urandom;
         tick();
      end
      idle_all();
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
